// File: rtl/phase_center_bank_ctrl.sv
// ----------------------------------------------------------------------------
// phase_center_bank_ctrl
//
// Sequences software updates of the double-buffered phase-center table.
//
// Single writes and full clear sweeps always target the shadow bank, which is
// the bank the datapath is not reading. A commit waits for the next frame
// sync and then swaps the banks, so the datapath never sees a half-updated
// table.
//
// Ports:
//   user_clk, user_rst_n   clock, asynchronous active-low reset
//   sw_addr, sw_data       target channel and center value from software
//   sw_ctrl                level commands: bit0 write, bit1 commit, bit2 clear
//   frame_sync             one-cycle pulse at channel 0 of the stream
//   ram_we/bank/addr/din   write port of the center RAM
//   active_bank            bank read by the datapath
//   busy                   high whenever the controller is not idle
//   commit_done            one-cycle pulse on a bank swap
//   wr_count               single writes since the last swap (saturating)
//   drop_err               sticky: a command edge was ignored
// ----------------------------------------------------------------------------
module phase_center_bank_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [2:0]        sw_ctrl,
  input  logic              frame_sync,
  output logic              ram_we,
  output logic              ram_bank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              active_bank,
  output logic              busy,
  output logic              commit_done,
  output logic [15:0]       wr_count,
  output logic              drop_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_CLEAR     = 2'd2,
    ST_WAIT_SYNC = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_q, state_d;
  logic [2:0]          prev_q, prev_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_bank_q, ram_bank_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                active_q, active_d;
  logic                busy_q, busy_d;
  logic                commit_done_q, commit_done_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                drop_err_q, drop_err_d;
  logic [2:0]          cmd_edge_s;

  // Rising edges of the software command levels. prev resets to all ones so a
  // level held high across reset release is not mistaken for a new command.
  assign cmd_edge_s = sw_ctrl & ~prev_q;
  assign prev_d     = sw_ctrl;

  // Next-state and registered-output logic of the command sequencer.
  always_comb begin
    state_d       = state_q;
    ram_we_d      = 1'b0;
    ram_bank_d    = ram_bank_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    active_d      = active_q;
    busy_d        = 1'b0;
    commit_done_d = 1'b0;
    wr_count_d    = wr_count_q;
    drop_err_d    = drop_err_q;

    case (state_q)
      ST_IDLE: begin
        // Priority clear > commit > write; losers are reported as drops.
        if (cmd_edge_s[2]) begin
          state_d    = ST_CLEAR;
          ram_we_d   = 1'b1;
          ram_addr_d = ADDR_ZERO;
          ram_din_d  = DATA_ZERO;
          busy_d     = 1'b1;
          drop_err_d = drop_err_q | cmd_edge_s[1] | cmd_edge_s[0];
        end else if (cmd_edge_s[1]) begin
          state_d    = ST_WAIT_SYNC;
          busy_d     = 1'b1;
          drop_err_d = drop_err_q | cmd_edge_s[0];
        end else if (cmd_edge_s[0]) begin
          state_d    = ST_WRITE;
          ram_we_d   = 1'b1;
          ram_addr_d = sw_addr;
          ram_din_d  = sw_data;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // The single write is on the RAM port this cycle; account for it.
        drop_err_d = drop_err_q | (|cmd_edge_s);
        state_d    = ST_IDLE;
        if (wr_count_q != 16'hFFFF) begin
          wr_count_d = wr_count_q + 16'd1;
        end else begin
          wr_count_d = wr_count_q;
        end
      end

      ST_CLEAR: begin
        // ram_addr_q doubles as the sweep pointer.
        drop_err_d = drop_err_q | (|cmd_edge_s);
        if (ram_addr_q == ADDR_LAST) begin
          state_d  = ST_IDLE;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_ONE;
          busy_d     = 1'b1;
        end
      end

      ST_WAIT_SYNC: begin
        drop_err_d = drop_err_q | (|cmd_edge_s);
        if (frame_sync) begin
          state_d       = ST_IDLE;
          active_d      = ~active_q;
          ram_bank_d    = active_q;
          commit_done_d = 1'b1;
          wr_count_d    = 16'd0;
        end else begin
          busy_d        = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep or pending commit.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= ST_IDLE;
      prev_q        <= 3'b111;
      ram_we_q      <= 1'b0;
      ram_bank_q    <= 1'b1;
      ram_addr_q    <= ADDR_ZERO;
      ram_din_q     <= DATA_ZERO;
      active_q      <= 1'b0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      wr_count_q    <= 16'd0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      ram_we_q      <= ram_we_d;
      ram_bank_q    <= ram_bank_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      active_q      <= active_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      wr_count_q    <= wr_count_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_bank    = ram_bank_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign active_bank = active_q;
  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign wr_count    = wr_count_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_phase_center_bank_ctrl.sv
// ----------------------------------------------------------------------------
// Directed bench for phase_center_bank_ctrl: a table of single writes plus
// hand-written sequences for clear sweeps, commits, drops and reset.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_phase_center_bank_ctrl;

  logic        user_clk;
  logic        user_rst_n;
  logic [7:0]  sw_addr;
  logic [31:0] sw_data;
  logic [2:0]  sw_ctrl;
  logic        frame_sync;
  logic        ram_we;
  logic        ram_bank;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic        active_bank;
  logic        busy;
  logic        commit_done;
  logic [15:0] wr_count;
  logic        drop_err;

  int n_cmp;
  int n_err;

  phase_center_bank_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .sw_addr     (sw_addr),
    .sw_data     (sw_data),
    .sw_ctrl     (sw_ctrl),
    .frame_sync  (frame_sync),
    .ram_we      (ram_we),
    .ram_bank    (ram_bank),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .active_bank (active_bank),
    .busy        (busy),
    .commit_done (commit_done),
    .wr_count    (wr_count),
    .drop_err    (drop_err)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_count;
  } wr_vec_t;

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " ram_we"},      {31'd0, ram_we},      32'd0);
    chk({tag, " ram_bank"},    {31'd0, ram_bank},    32'd1);
    chk({tag, " ram_addr"},    {24'd0, ram_addr},    32'd0);
    chk({tag, " ram_din"},     ram_din,              32'd0);
    chk({tag, " active_bank"}, {31'd0, active_bank}, 32'd0);
    chk({tag, " busy"},        {31'd0, busy},        32'd0);
    chk({tag, " commit_done"}, {31'd0, commit_done}, 32'd0);
    chk({tag, " wr_count"},    {16'd0, wr_count},    32'd0);
    chk({tag, " drop_err"},    {31'd0, drop_err},    32'd0);
  endtask

  task automatic do_reset();
    sw_ctrl    = 3'b000;
    frame_sync = 1'b0;
    user_rst_n = 1'b0;
    repeat (2) tick();
    user_rst_n = 1'b1;
    tick();
  endtask

  wr_vec_t vecs [3];
  int      seen_we;

  initial begin
    n_cmp = 0;
    n_err = 0;
    sw_addr = 8'h00;
    sw_data = 32'h0;
    vecs[0] = '{addr: 8'h05, data: 32'hDEADBEEF, exp_count: 16'd1};
    vecs[1] = '{addr: 8'hFF, data: 32'h12345678, exp_count: 16'd2};
    vecs[2] = '{addr: 8'h00, data: 32'hA5A5A5A5, exp_count: 16'd3};

    do_reset();
    chk_reset_values("reset");

    // Table of single writes, each with the level held for an extra cycle.
    for (int v = 0; v < 3; v++) begin
      sw_ctrl = 3'b000;
      tick();
      sw_addr = vecs[v].addr;
      sw_data = vecs[v].data;
      sw_ctrl = 3'b001;
      tick();
      sw_addr = 8'h77;
      sw_data = 32'h0BADF00D;
      chk("wr ram_we",   {31'd0, ram_we},   32'd1);
      chk("wr busy",     {31'd0, busy},     32'd1);
      chk("wr ram_addr", {24'd0, ram_addr}, {24'd0, vecs[v].addr});
      chk("wr ram_din",  ram_din,           vecs[v].data);
      chk("wr ram_bank", {31'd0, ram_bank}, 32'd1);
      tick();
      chk("wr we off",   {31'd0, ram_we},   32'd0);
      chk("wr busy off", {31'd0, busy},     32'd0);
      chk("wr count",    {16'd0, wr_count}, {16'd0, vecs[v].exp_count});
      chk("wr addr hold", {24'd0, ram_addr}, {24'd0, vecs[v].addr});
      tick();
      chk("wr no retrig", {31'd0, ram_we},  32'd0);
    end

    // Clear sweep with a write edge injected mid-sweep.
    sw_ctrl = 3'b000;
    tick();
    sw_ctrl = 3'b100;
    tick();
    for (int i = 0; i < 256; i++) begin
      chk("clr ram_we",   {31'd0, ram_we},   32'd1);
      chk("clr busy",     {31'd0, busy},     32'd1);
      chk("clr ram_addr", {24'd0, ram_addr}, i);
      chk("clr ram_din",  ram_din,           32'd0);
      if (i == 20) chk("clr drop before", {31'd0, drop_err}, 32'd0);
      if (i == 20) sw_ctrl = 3'b101;
      tick();
    end
    chk("clr end we",    {31'd0, ram_we},   32'd0);
    chk("clr end busy",  {31'd0, busy},     32'd0);
    chk("clr wr_count",  {16'd0, wr_count}, 32'd3);
    chk("clr drop_err",  {31'd0, drop_err}, 32'd1);
    tick();
    chk("clr no late wr", {31'd0, ram_we},  32'd0);

    // Commit with frame_sync 10 cycles after the command.
    sw_ctrl = 3'b000;
    tick();
    sw_ctrl = 3'b010;
    tick();
    chk("cmt busy", {31'd0, busy}, 32'd1);
    repeat (9) tick();
    chk("cmt wait active", {31'd0, active_bank}, 32'd0);
    chk("cmt wait busy",   {31'd0, busy},        32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("cmt active",   {31'd0, active_bank}, 32'd1);
    chk("cmt done",     {31'd0, commit_done}, 32'd1);
    chk("cmt wr_count", {16'd0, wr_count},    32'd0);
    chk("cmt busy off", {31'd0, busy},        32'd0);
    chk("cmt ram_bank", {31'd0, ram_bank},    32'd0);
    tick();
    chk("cmt done pulse", {31'd0, commit_done}, 32'd0);

    // Commit edge coinciding with frame_sync: that sync must be ignored.
    sw_ctrl = 3'b000;
    tick();
    sw_ctrl    = 3'b010;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sim busy",   {31'd0, busy},        32'd1);
    chk("sim active", {31'd0, active_bank}, 32'd1);
    chk("sim done",   {31'd0, commit_done}, 32'd0);
    repeat (3) tick();
    chk("sim still waiting", {31'd0, active_bank}, 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sim swap",     {31'd0, active_bank}, 32'd0);
    chk("sim done2",    {31'd0, commit_done}, 32'd1);
    chk("sim ram_bank", {31'd0, ram_bank},    32'd1);

    // Write and clear edges together: clear wins, write is dropped.
    do_reset();
    sw_ctrl = 3'b101;
    tick();
    chk("wc drop_err", {31'd0, drop_err}, 32'd1);
    seen_we = 0;
    for (int i = 0; i < 256; i++) begin
      chk("wc ram_addr", {24'd0, ram_addr}, i);
      chk("wc ram_din",  ram_din,           32'd0);
      seen_we += int'(ram_we);
      tick();
    end
    chk("wc we count", seen_we, 32'd256);
    chk("wc we off",   {31'd0, ram_we},   32'd0);
    chk("wc wr_count", {16'd0, wr_count}, 32'd0);

    // Reset in the middle of a sweep at address 100.
    sw_ctrl = 3'b000;
    tick();
    sw_ctrl = 3'b100;
    tick();
    repeat (100) tick();
    chk("rst at addr", {24'd0, ram_addr}, 32'd100);
    user_rst_n = 1'b0;
    #1;
    chk_reset_values("mid-sweep reset");

    // Levels held high through reset release must not execute.
    sw_ctrl = 3'b111;
    repeat (2) tick();
    #2;
    user_rst_n = 1'b1;
    seen_we = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_we += int'(ram_we) + int'(busy);
    end
    chk("held level no cmd", seen_we, 32'd0);
    chk_reset_values("held level");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
